gray_counter: RTL and testbench

- Synchronous up/down counter whose registered output is Gray-coded; sits directly upstream of the Gray-to-binary converter stage and feeds it.
- Used for pointer and position tracking where only one output bit may change per step.
- Counts internally in binary and registers the Gray encoding of the next value, so the Gray output carries no extra cycle of latency.
- Supports synchronous clear, binary load, direction control, wrap or saturate mode, and a terminal-count pulse.

---
 rtl/gray_counter.sv | 102 ++++++++++
 tb/tb_gray_counter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-coded output, terminal-count pulse and
// optional sticky Gray-step checker (enable with `define GRAY_COUNTER_ERRCHK_EN).
module gray_counter #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             err
);

  localparam bit SAT = (SATURATE != 0);

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic at_terminal(input logic [WIDTH-1:0] c, input logic up);
    return up ? (&c) : ~(|c);
  endfunction

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             term;

  assign term = at_terminal(count_q, up_dn);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      tc_d = term;
      // A saturated boundary attempt still pulses tc but leaves the count alone.
      if (!(term && SAT)) begin
        count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
    gray_d = to_gray(count_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      gray_q  <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= gray_d;
      tc_q    <= tc_d;
    end
  end

  assign gray = gray_q;
  assign tc   = tc_q;

`ifdef GRAY_COUNTER_ERRCHK_EN
  function automatic logic is_onehot(input logic [WIDTH-1:0] x);
    return (x != '0) && ((x & (x - 1'b1)) == '0);
  endfunction

  logic             step;
  logic             chk_q;
  logic [WIDTH-1:0] prev_q;
  logic             err_q;

  // Only enabled steps that actually move the count are checked.
  assign step = en && !clr && !load && !(term && SAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q  <= 1'b0;
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      chk_q  <= step;
      prev_q <= gray_q;
      if (clr) begin
        err_q <= 1'b0;
      end else if (chk_q && !is_onehot(gray_q ^ prev_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: one wrapping and one saturating instance share stimulus.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic [7:0] gray_w, gray_s;
  logic       tc_w, tc_s, err_w, err_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .gray(gray_w), .tc(tc_w), .err(err_w)
  );

  gray_counter #(.WIDTH(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .gray(gray_s), .tc(tc_s), .err(err_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq5 [5];

  initial begin
    seq5 = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};

    #12;
    chk("rst_gray_w", gray_w, 8'h00);
    chk("rst_gray_s", gray_s, 8'h00);
    chk("rst_tc_w", tc_w, 1'b0);
    chk("rst_err_w", err_w, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("up%0d_gray", i), gray_w, seq5[i]);
      chk($sformatf("up%0d_tc", i), tc_w, 1'b0);
    end

    en = 1'b0; load = 1'b1; load_val = 8'h7F;
    tick();
    chk("ld7f_gray", gray_w, 8'h40);
    load = 1'b0; en = 1'b1;
    tick();
    chk("ld7f_step_gray", gray_w, 8'hC0);
    chk("ld7f_step_tc", tc_w, 1'b0);

    en = 1'b0; load = 1'b1; load_val = 8'hFF;
    tick();
    chk("ldff_gray_w", gray_w, 8'h80);
    chk("ldff_gray_s", gray_s, 8'h80);
    chk("ldff_tc", tc_w, 1'b0);
    load = 1'b0; en = 1'b1;
    tick();
    chk("wrap_up_gray", gray_w, 8'h00);
    chk("wrap_up_tc", tc_w, 1'b1);
    chk("sat_up_gray", gray_s, 8'h80);
    chk("sat_up_tc", tc_s, 1'b1);
    en = 1'b0;
    tick();
    chk("wrap_up_tc_drop", tc_w, 1'b0);
    chk("sat_up_tc_drop", tc_s, 1'b0);
    chk("wrap_hold_gray", gray_w, 8'h00);

    load = 1'b1; load_val = 8'h00;
    tick();
    chk("ld00_gray_s", gray_s, 8'h00);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    chk("sat_dn1_gray", gray_s, 8'h00);
    chk("sat_dn1_tc", tc_s, 1'b1);
    chk("wrap_dn1_gray", gray_w, 8'h80);
    chk("wrap_dn1_tc", tc_w, 1'b1);
    tick();
    chk("sat_dn2_gray", gray_s, 8'h00);
    chk("sat_dn2_tc", tc_s, 1'b1);
    chk("wrap_dn2_gray", gray_w, 8'h81);
    chk("wrap_dn2_tc", tc_w, 1'b0);
    up_dn = 1'b1;
    tick();
    chk("sat_rev_gray", gray_s, 8'h01);
    chk("sat_rev_tc", tc_s, 1'b0);
    chk("wrap_rev_gray", gray_w, 8'h80);
    chk("wrap_rev_tc", tc_w, 1'b0);

    clr = 1'b1; load = 1'b1; load_val = 8'h33; en = 1'b1;
    tick();
    chk("clr_all_gray_w", gray_w, 8'h00);
    chk("clr_all_gray_s", gray_s, 8'h00);
    chk("clr_all_tc", tc_w, 1'b0);
    clr = 1'b0; load = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_gray", gray_w, 8'h02);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gray_w", gray_w, 8'h00);
    chk("async_rst_gray_s", gray_s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    load = 1'b1; load_val = 8'h10; en = 1'b1;
    tick();
    chk("ld_beats_en_gray", gray_w, 8'h18);
    chk("ld_beats_en_tc", tc_w, 1'b0);
    load = 1'b0; en = 1'b0;
    tick();
    chk("hold_gray", gray_w, 8'h18);
    chk("hold_tc", tc_w, 1'b0);
    chk("err_w_clean", err_w, 1'b0);
    chk("err_s_clean", err_s, 1'b0);

`ifdef GRAY_COUNTER_ERRCHK_EN
    begin
      logic [7:0] g;
      en = 1'b1;
      for (int i = 0; i < 512; i++) begin
        up_dn = 1'($urandom_range(0, 1));
        tick();
        chk("rand_err", err_w, 1'b0);
      end
      en = 1'b0;
      tick();
      chk("rand_err_final", err_w, 1'b0);
      g = ~u_wrap.gray_q;
      force u_wrap.gray_q = g;
      en = 1'b1; up_dn = 1'b1;
      tick();
      release u_wrap.gray_q;
      en = 1'b0;
      tick();
      chk("inject_err_set", err_w, 1'b1);
      en = 1'b1;
      tick();
      tick();
      chk("inject_err_sticky", err_w, 1'b1);
      en = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("inject_err_clr", err_w, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
